// File: rtl/instr_encoder_loader_pkg.sv
// Shared opcode type codes, AVR encoding prefixes and the symbolic-to-word encoder.
package instr_encoder_loader_pkg;

    localparam int unsigned OPCODE_COUNT = 4;

    typedef enum logic [OPCODE_COUNT-1:0] {
        TYPE_NOP = 4'h0,
        TYPE_ADD = 4'h1,
        TYPE_ADC = 4'h2,
        TYPE_SUB = 4'h3,
        TYPE_AND = 4'h4,
        TYPE_OR  = 4'h5,
        TYPE_NEG = 4'h6
    } opcode_e;

    localparam logic [5:0] ENC_ADC_PFX = 6'b000111;
    localparam logic [5:0] ENC_ADD_PFX = 6'b000011;
    localparam logic [5:0] ENC_SUB_PFX = 6'b000110;
    localparam logic [5:0] ENC_AND_PFX = 6'b001000;
    localparam logic [5:0] ENC_OR_PFX  = 6'b001010;
    localparam logic [6:0] ENC_NEG_PFX = 7'b1001010;
    localparam logic [3:0] ENC_NEG_LO  = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic        known;
        logic [15:0] word;
    } enc_t;

    function automatic enc_t encode_instr(input logic [OPCODE_COUNT-1:0] typ,
                                          input logic [4:0] rd,
                                          input logic [4:0] rr);
        enc_t e;
        e.known = 1'b1;
        e.word  = '0;
        case (typ)
            TYPE_ADC: e.word = {ENC_ADC_PFX, rr[4], rd, rr[3:0]};
            TYPE_ADD: e.word = {ENC_ADD_PFX, rr[4], rd, rr[3:0]};
            TYPE_SUB: e.word = {ENC_SUB_PFX, rr[4], rd, rr[3:0]};
            TYPE_AND: e.word = {ENC_AND_PFX, rr[4], rd, rr[3:0]};
            TYPE_OR:  e.word = {ENC_OR_PFX,  rr[4], rd, rr[3:0]};
            TYPE_NEG: e.word = {ENC_NEG_PFX, rd, ENC_NEG_LO};
            TYPE_NOP: e.word = '0;
            default:  e.known = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request stream (symbolic instruction in) and program-memory write port.
interface instr_encoder_loader_if #(
    parameter int unsigned INSTR_WIDTH  = 16,
    parameter int unsigned R_ADDR_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH   = 8
) ();
    import instr_encoder_loader_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [OPCODE_COUNT-1:0] in_type;
    logic [R_ADDR_WIDTH-1:0] in_rd;
    logic [R_ADDR_WIDTH-1:0] in_rr;
    logic                    in_last;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [INSTR_WIDTH-1:0]  mem_wdata;
    logic                    mem_ready;

    modport slave (
        input  in_valid, in_type, in_rd, in_rr, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_type, in_rd, in_rr, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Synchronous FIFO with flush; pointer MSB distinguishes full from empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into AVR words and streams them into
// consecutive program-memory addresses through a small FIFO.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 16,
    parameter int unsigned R_ADDR_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    instr_encoder_loader_if.slave bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_unknown_o,
    output logic                  err_overflow_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);
    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     word_count_q;
    logic                    err_unknown_q;
    logic                    err_overflow_q;

    logic [R_ADDR_WIDTH-1:0] rd;
    logic [R_ADDR_WIDTH-1:0] rr;
    enc_t                    enc;
    logic                    accept;
    logic                    push;
    logic                    wr_fire;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [INSTR_WIDTH-1:0]  fifo_head;

    assign rd = bus.in_rd;
    assign rr = bus.in_rr;

    always_comb begin
        enc = encode_instr(bus.in_type, rd, rr);
    end

    assign bus.in_ready  = (state_q == ST_LOAD) && !fifo_full;
    assign bus.mem_we    = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_DRAIN));
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = fifo_head;

    assign accept  = bus.in_valid && bus.in_ready;
    // A restart flushes the FIFO, so anything offered in that cycle is dropped.
    assign push    = accept && enc.known && !start_i;
    assign wr_fire = bus.mem_we && bus.mem_ready;

    sync_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (start_i),
        .push_i  (push),
        .pop_i   (wr_fire),
        .wdata_i (enc.word),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            word_count_q   <= '0;
            err_unknown_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else if (start_i) begin
            state_q        <= ST_LOAD;
            addr_q         <= base_addr_i;
            word_count_q   <= '0;
            err_unknown_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                addr_q       <= addr_q + ADDR_WIDTH'(1);
                word_count_q <= word_count_q + (ADDR_WIDTH+1)'(1);
                if (addr_q == '1) begin
                    err_overflow_q <= 1'b1;
                end
            end
            if (accept && !enc.known) begin
                err_unknown_q <= 1'b1;
            end
            case (state_q)
                ST_LOAD:  if (accept && bus.in_last) state_q <= ST_DRAIN;
                ST_DRAIN: if (fifo_empty) state_q <= ST_DONE;
                default:  ;
            endcase
        end
    end

    assign busy_o         = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done_o         = (state_q == ST_DONE);
    assign err_unknown_o  = err_unknown_q;
    assign err_overflow_o = err_overflow_q;
    assign word_count_o   = word_count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a queue model of expected memory writes checked on every write.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic       busy, done, err_unk, err_ovf;
    logic [8:0] word_count;

    instr_encoder_loader_if #(.INSTR_WIDTH(16), .R_ADDR_WIDTH(5), .ADDR_WIDTH(8)) bus ();

    instr_encoder_loader #(
        .INSTR_WIDTH  (16),
        .R_ADDR_WIDTH (5),
        .ADDR_WIDTH   (8),
        .FIFO_DEPTH   (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .base_addr_i    (base_addr),
        .bus            (bus),
        .busy_o         (busy),
        .done_o         (done),
        .err_unknown_o  (err_unk),
        .err_overflow_o (err_ovf),
        .word_count_o   (word_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  m_addr;
    int          m_count;
    bit          m_unk, m_ovf;
    logic [7:0]  log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    int          last_acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word from the AVR field layout: prefix<<10 | rr[4]<<9 | rd<<4 | rr[3:0].
    function automatic bit model_word(input logic [3:0] typ, input int rd, input int rr,
                                      output logic [15:0] w);
        int pfx;
        w = 16'h0000;
        case (typ)
            TYPE_ADC: pfx = 7;
            TYPE_ADD: pfx = 3;
            TYPE_SUB: pfx = 6;
            TYPE_AND: pfx = 8;
            TYPE_OR:  pfx = 10;
            TYPE_NEG: begin w = 16'(32'h9401 + rd * 16); return 1'b1; end
            TYPE_NOP: return 1'b1;
            default:  return 1'b0;
        endcase
        w = 16'(pfx * 1024 + (rr / 16) * 512 + rd * 16 + (rr % 16));
        return 1'b1;
    endfunction

    task automatic model_accept(input logic [3:0] typ, input int rd, input int rr);
        logic [15:0] w;
        wr_t e;
        if (model_word(typ, rd, rr, w)) begin
            e.addr = m_addr;
            e.data = w;
            exp_q.push_back(e);
            if (m_addr == 8'hFF) m_ovf = 1'b1;
            m_addr = m_addr + 8'd1;
            m_count++;
        end else begin
            m_unk = 1'b1;
        end
    endtask

    always @(negedge clk) begin : compare
        wr_t e;
        if (rst_n && bus.mem_we && bus.mem_ready) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
            log_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic do_start(input logic [7:0] b);
        base_addr = b;
        start = 1'b1;
        step();
        start = 1'b0;
        m_addr = b;
        m_count = 0;
        m_unk = 1'b0;
        m_ovf = 1'b0;
        exp_q.delete();
        clear_log();
    endtask

    task automatic try_send(input logic [3:0] typ, input int rd, input int rr, input bit last,
                            input int budget, output bit ok);
        bus.in_valid = 1'b1;
        bus.in_type  = typ;
        bus.in_rd    = 5'(rd);
        bus.in_rr    = 5'(rr);
        bus.in_last  = last;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                last_acc_cyc = cyc;
                model_accept(typ, rd, rr);
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send(input logic [3:0] typ, input int rd, input int rr, input bit last);
        bit ok;
        try_send(typ, rd, rr, last, 50, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never high for type 0x%0h", typ);
        end
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 200 && !done; n++) @(negedge clk);
        check(name, 32'(done), 32'd1);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_word_count"}, 32'(word_count), 32'(m_count));
        check({tag, "_err_unknown"}, 32'(err_unk), 32'(m_unk));
        check({tag, "_err_overflow"}, 32'(err_ovf), 32'(m_ovf));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err_unknown"}, 32'(err_unk), 32'd0);
        check({tag, "_err_overflow"}, 32'(err_ovf), 32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        bit ok;
        logic [7:0]  h_addr;
        logic [15:0] h_data;

        bus.in_valid  = 1'b0;
        bus.in_type   = '0;
        bus.in_rd     = '0;
        bus.in_rr     = '0;
        bus.in_last   = 1'b0;
        bus.mem_ready = 1'b1;
        m_addr = '0; m_count = 0; m_unk = 1'b0; m_ovf = 1'b0;

        #2;
        check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1: single ADC, one-cycle latency from accept to write
        do_start(8'h10);
        send(TYPE_ADC, 3, 17, 1'b1);
        wait_done("t1_done");
        check("t1_nwrites", 32'(log_data.size()), 32'd1);
        check("t1_addr_lit", 32'(log_addr[0]), 32'h10);
        check("t1_data_lit", 32'(log_data[0]), 32'h1E31);
        check("t1_latency", 32'(log_cyc[0]), 32'(last_acc_cyc + 1));
        check("t1_word_count_lit", 32'(word_count), 32'd1);
        end_checks("t1");

        // 2: NEG, NOP, OR back to back
        do_start(8'h00);
        send(TYPE_NEG, 31, 0, 1'b0);
        send(TYPE_NOP, 0, 0, 1'b0);
        send(TYPE_OR, 0, 31, 1'b1);
        wait_done("t2_done");
        check("t2_nwrites", 32'(log_data.size()), 32'd3);
        check("t2_data0_lit", 32'(log_data[0]), 32'h95F1);
        check("t2_data1_lit", 32'(log_data[1]), 32'h0000);
        check("t2_data2_lit", 32'(log_data[2]), 32'h2A0F);
        check("t2_addr2_lit", 32'(log_addr[2]), 32'h02);
        check("t2_consec1", 32'(log_cyc[1]), 32'(log_cyc[0] + 1));
        check("t2_consec2", 32'(log_cyc[2]), 32'(log_cyc[1] + 1));
        end_checks("t2");

        // 3: memory stall fills the FIFO; head must hold
        do_start(8'h20);
        bus.mem_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            try_send(TYPE_ADD, i + 1, 20 + i, 1'b0, 2, ok);
            if (ok) acc++;
        end
        check("t3_stall_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        h_addr = bus.mem_addr;
        h_data = bus.mem_wdata;
        check("t3_hold_addr_lit", 32'(h_addr), 32'h20);
        check("t3_hold_data_lit", 32'(h_data), 32'h0E14);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_hold_we", 32'(bus.mem_we), 32'd1);
            check("t3_hold_addr", 32'(bus.mem_addr), 32'(h_addr));
            check("t3_hold_data", 32'(bus.mem_wdata), 32'(h_data));
        end
        step();
        bus.mem_ready = 1'b1;
        send(TYPE_ADD, 5, 24, 1'b0);
        send(TYPE_ADD, 6, 25, 1'b1);
        wait_done("t3_done");
        check("t3_nwrites", 32'(log_data.size()), 32'd6);
        check("t3_addr5_lit", 32'(log_addr[5]), 32'h25);
        end_checks("t3");

        // 4: unknown type between two ADDs is consumed but not written
        do_start(8'h30);
        send(TYPE_ADD, 1, 2, 1'b0);
        send(4'hF, 7, 7, 1'b0);
        send(TYPE_ADD, 3, 4, 1'b1);
        wait_done("t4_done");
        check("t4_err_unknown_lit", 32'(err_unk), 32'd1);
        check("t4_nwrites", 32'(log_data.size()), 32'd2);
        check("t4_addr1_lit", 32'(log_addr[1]), 32'h31);
        check("t4_word_count_lit", 32'(word_count), 32'd2);
        end_checks("t4");

        // Session whose only request is unknown
        do_start(8'h50);
        send(4'hE, 1, 1, 1'b1);
        wait_done("t4b_done");
        check("t4b_word_count_lit", 32'(word_count), 32'd0);
        end_checks("t4b");

        // 5: address wrap past 0xFF
        do_start(8'hFF);
        send(TYPE_SUB, 1, 2, 1'b0);
        send(TYPE_SUB, 3, 4, 1'b1);
        wait_done("t5_done");
        check("t5_addr0_lit", 32'(log_addr[0]), 32'hFF);
        check("t5_addr1_lit", 32'(log_addr[1]), 32'h00);
        check("t5_err_overflow_lit", 32'(err_ovf), 32'd1);
        end_checks("t5");

        // 6: asynchronous reset mid-LOAD with three words buffered
        do_start(8'h40);
        bus.mem_ready = 1'b0;
        send(TYPE_AND, 2, 3, 1'b0);
        send(TYPE_OR, 4, 5, 1'b0);
        send(TYPE_NEG, 6, 0, 1'b0);
        @(negedge clk);
        check("t6_pre_mem_we", 32'(bus.mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_count = 0; m_unk = 1'b0; m_ovf = 1'b0;
        #1;
        check_all_zero("t6_async");
        step();
        step();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        clear_log();
        repeat (6) step();
        check("t6_no_writes", 32'(log_data.size()), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_done", 32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Reverse of the core's instruction decoder. Accepts symbolic instructions (opcode type + Rd + Rr) over a valid/ready stream and encodes each one into a 16-bit AVR instruction word. Buffers the words in a small FIFO and writes them to consecutive program-memory addresses. Used by lab benches and the boot/program loader to fill instruction memory that the decode stage later reads back.

Parameters:
INSTR_WIDTH, 16, instruction word width
R_ADDR_WIDTH, 5, register address width
ADDR_WIDTH, 8, program memory address width
FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse: begin a load session at base_addr
base_addr  in  ADDR_WIDTH  first write address, sampled on start
in_valid  in  1  instruction request valid
in_ready  out  1  encoder can accept a request
in_type  in  `OPCODE_COUNT  opcode type, shared `TYPE_* codes
in_rd  in  R_ADDR_WIDTH  destination register
in_rr  in  R_ADDR_WIDTH  source register (ignored for NEG/NOP)
in_last  in  1  marks final instruction of the session
mem_we  out  1  program memory write request
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  INSTR_WIDTH  encoded word
mem_ready  in  1  memory accepts the write this cycle
busy  out  1  state is LOAD or DRAIN
done  out  1  session complete, held until next start
err_unknown  out  1  sticky: an unsupported type was received
err_overflow  out  1  sticky: address wrapped past 2^ADDR_WIDTH-1
word_count  out  ADDR_WIDTH+1  words written this session

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty; all outputs 0, including in_ready, mem_*, flags and word_count.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE --start--> LOAD.
  - LOAD --accept with in_last--> DRAIN.
  - DRAIN --FIFO empty and no write pending--> DONE.
  - start in any state restarts the session: flush FIFO, clear word_count, err_unknown, err_overflow and done; address = base_addr; go to LOAD.
- Accept rule: in_ready = (state==LOAD) && !fifo_full.
  - Accept happens when in_valid && in_ready.
  - Push and pop in the same cycle is legal when not full.
  - Push is never allowed while full, even with a simultaneous pop.
- Encoding (combinational, pushed on accept):
  - ADC: {6'b000111, rr[4], rd, rr[3:0]}
  - ADD: {6'b000011, rr[4], rd, rr[3:0]}
  - SUB: {6'b000110, rr[4], rd, rr[3:0]}
  - AND: {6'b001000, rr[4], rd, rr[3:0]}
  - OR: {6'b001010, rr[4], rd, rr[3:0]}
  - NEG: {7'b1001010, rd, 4'b0001}
  - NOP: 16'h0000
  - Any other type: nothing is pushed; err_unknown is set. The request is still consumed, and in_last still takes effect.
- Write side:
  - mem_we = FIFO non-empty && state in {LOAD, DRAIN}.
  - mem_wdata = FIFO head.
  - A write completes on mem_we && mem_ready. On completion: pop, address +1, word_count +1.
  - mem_addr and mem_wdata stay stable while mem_we && !mem_ready.
- Latency: a word accepted at cycle t drives mem_we at t+1 at the earliest (FIFO empty, mem_ready=1). Sustained throughput is 1 word/cycle.
- Address wrap: completing a write at address 2^ADDR_WIDTH-1 wraps the address to 0 and sets err_overflow. Loading continues.
- done = (state==DONE).
- A session whose only word is unknown, or that has zero valid words, reaches DONE with word_count=0.

Decomposition:
- defines.vh gets `ENC_ADC_PFX`, `ENC_ADD_PFX`, `ENC_SUB_PFX`, `ENC_AND_PFX`, `ENC_OR_PFX` (6-bit prefixes) and `ENC_NEG_PFX`/`ENC_NEG_LO`, next to the existing `TYPE_*` codes. The decoder and encoder share them.
- One sub-module: sync_fifo (parameterised width/depth, full/empty, push/pop, flush).

Test Plan:
1. start base=0x10, then ADC rd=3 rr=17 last=1 -> one write: addr 0x10, data 0x1E31; done=1, word_count=1.
2. Stream NEG rd=31, NOP, OR rd=0 rr=31 (last on OR), mem_ready=1 -> writes 0x95F1 @0, 0x0000 @1, 0x2A0F @2 on consecutive cycles; done follows.
3. mem_ready=0 for 10 cycles, 6 requests offered -> in_ready drops after 4 accepts; mem_addr/mem_wdata held constant. Release mem_ready -> all 6 written in order.
4. Unknown type between two ADDs -> err_unknown=1; only 2 writes at consecutive addresses; word_count=2.
5. base=0xFF, two SUBs -> writes at 0xFF then 0x00; err_overflow=1.
6. rst_n low mid-LOAD with FIFO holding 3 words -> all outputs 0 immediately (asynchronous), state IDLE, no writes after release until start.
